// File: rtl/lnl_kbd_input_fifo.sv
// Keyboard input port: synchronised, edge-detected strobe pushes words into a circular buffer.
// First-word-fall-through head; drops words and sets a sticky overflow flag when full.
module lnl_kbd_input_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          kbd_data,
    input  logic                       kbd_strobe,
    input  logic                       cpu_rd,
    input  logic                       ien,
    input  logic                       ovf_clr,
    output logic [DATA_W-1:0]          cpu_data,
    output logic                       fgi,
    output logic                       irq,
    output logic                       full,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic push_req, pop, push_ok, full_w, empty_w;

    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign empty_w  = (count_q == '0);
    assign push_req = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign pop      = cpu_rd & ~empty_w;
    // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
    assign push_ok  = push_req & (~full_w | pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push_ok) count_d = count_q - 1'b1;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], kbd_strobe};
            prev_q  <= sync_q[SYNC_STAGES-1];
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= kbd_data;
    end

    assign cpu_data = empty_w ? '0 : mem_q[rptr_q];
    assign fgi      = ~empty_w;
    assign irq      = ien & ~empty_w;
    assign full     = full_w;
    assign ovf      = ovf_q;
    assign count    = count_q;
endmodule
